// File: rtl/tid_launch_pkg.sv
// Shared types and helpers for the TID launch controller.
package tid_launch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } launch_state_e;

   function automatic int unsigned tid_width(input int unsigned total);
      return $clog2(total + 1);
   endfunction

endpackage

// File: rtl/tid_launch_controller_credit_counter.sv
// Up/down in-flight credit counter bounded to [0, MAX]; retires at zero are dropped and flagged.
module credit_counter #(
   parameter  int unsigned MAX = 16,
   localparam int unsigned CW  = $clog2(MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_nxt,
   output logic          full,
   output logic          underflow
);

   logic [CW-1:0] count_q, count_d;
   logic          dec_ok;

   always_comb begin
      dec_ok    = dec && (count_q != '0);
      underflow = dec && (count_q == '0);
      full      = (count_q == CW'(MAX));
      count_d   = count_q;
      if (inc && !full) begin
         if (!dec_ok) begin
            count_d = count_q + 1'b1;
         end
      end else if (dec_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign count_nxt = count_d;

endmodule

// File: rtl/tid_launch_controller.sv
// Flow-controlled, completion-tracked TID issue for one CGRA kernel launch.
// Optional perf counters enabled by defining TID_LAUNCH_PERF_EN.
module tid_launch_controller
   import tid_launch_pkg::*;
#(
   parameter  int unsigned TOTAL_TID    = 512,
   parameter  int unsigned MAX_INFLIGHT = 16,
   localparam int unsigned TIDW         = tid_width(TOTAL_TID),
   localparam int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            launch_valid,
   output logic            launch_ready,
   input  logic [TIDW-1:0] launch_max_tid,
   input  logic            abort,
   output logic            tid_valid,
   input  logic            tid_ready,
   output logic [TIDW-1:0] tid,
   input  logic            retire_valid,
`ifdef TID_LAUNCH_PERF_EN
   output logic [31:0]     issue_stall_cycles,
   output logic [31:0]     launch_cycles,
`endif
   output logic [CW-1:0]   inflight,
   output logic            busy,
   output logic            done,
   output logic            aborted,
   output logic            err_retire
);

   localparam logic [TIDW-1:0] TID_LAST = TIDW'(TOTAL_TID - 1);

   launch_state_e   state_q, state_d;
   logic [TIDW-1:0] next_tid_q, next_tid_d;
   logic [TIDW-1:0] max_tid_q, max_tid_d;
   logic            aborted_q, aborted_d;
   logic            err_q, err_d;
   logic            issue_hs, accept;
   logic            cc_full, cc_underflow;
   logic [CW-1:0]   cc_count, cc_count_nxt;

   // Valid depends only on state and credit count, so no input reaches an output.
   assign tid_valid    = (state_q == ISSUE) && !cc_full;
   assign issue_hs     = tid_valid && tid_ready;
   assign accept       = (state_q == IDLE) && launch_valid;
   assign tid          = next_tid_q;
   assign inflight     = cc_count;
   assign launch_ready = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign aborted      = aborted_q;
   assign err_retire   = err_q;

   credit_counter #(
      .MAX (MAX_INFLIGHT)
   ) u_credit (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (issue_hs),
      .dec       (retire_valid),
      .count     (cc_count),
      .count_nxt (cc_count_nxt),
      .full      (cc_full),
      .underflow (cc_underflow)
   );

   always_comb begin
      state_d    = state_q;
      next_tid_d = next_tid_q;
      max_tid_d  = max_tid_q;
      aborted_d  = aborted_q;
      err_d      = err_q | cc_underflow;
      unique case (state_q)
         IDLE: begin
            if (launch_valid) begin
               max_tid_d  = (launch_max_tid > TID_LAST) ? TID_LAST : launch_max_tid;
               next_tid_d = '0;
               aborted_d  = 1'b0;
               err_d      = cc_underflow;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (issue_hs) begin
               if (next_tid_q == max_tid_q) begin
                  state_d = DRAIN;
               end else begin
                  next_tid_d = next_tid_q + 1'b1;
               end
            end
            if (abort) begin
               state_d   = DRAIN;
               aborted_d = 1'b1;
            end
         end
         DRAIN: begin
            if (cc_count_nxt == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         next_tid_q <= '0;
         max_tid_q  <= '0;
         aborted_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         next_tid_q <= next_tid_d;
         max_tid_q  <= max_tid_d;
         aborted_q  <= aborted_d;
         err_q      <= err_d;
      end
   end

`ifdef TID_LAUNCH_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] lcyc_q, lcyc_d;

   // The accept cycle itself counts as the first launch cycle.
   always_comb begin
      stall_d = stall_q;
      lcyc_d  = lcyc_q;
      if (accept) begin
         stall_d = '0;
         lcyc_d  = 32'd1;
      end else if (state_q != IDLE) begin
         if (lcyc_q != '1) begin
            lcyc_d = lcyc_q + 32'd1;
         end
         if ((state_q == ISSUE) && (!tid_valid || !tid_ready) && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         lcyc_q  <= '0;
      end else begin
         stall_q <= stall_d;
         lcyc_q  <= lcyc_d;
      end
   end

   assign issue_stall_cycles = stall_q;
   assign launch_cycles      = lcyc_q;
`endif

endmodule

// File: tb/tb_tid_launch_controller.sv
// Self-checking bench for tid_launch_controller against a launch-level reference model.
module tb_tid_launch_controller;

   localparam int unsigned TOTAL = 512;
   localparam int unsigned MAXI  = 4;
   localparam int unsigned TIDW  = 10;
   localparam int unsigned CW    = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            launch_valid;
   logic            launch_ready;
   logic [TIDW-1:0] launch_max_tid;
   logic            abort;
   logic            tid_valid;
   logic            tid_ready;
   logic [TIDW-1:0] tid;
   logic            retire_valid;
   logic [CW-1:0]   inflight;
   logic            busy;
   logic            done;
   logic            aborted;
   logic            err_retire;

   always #5 clk = ~clk;

   tid_launch_controller #(
      .TOTAL_TID    (TOTAL),
      .MAX_INFLIGHT (MAXI)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .launch_valid   (launch_valid),
      .launch_ready   (launch_ready),
      .launch_max_tid (launch_max_tid),
      .abort          (abort),
      .tid_valid      (tid_valid),
      .tid_ready      (tid_ready),
      .tid            (tid),
      .retire_valid   (retire_valid),
      .inflight       (inflight),
      .busy           (busy),
      .done           (done),
      .aborted        (aborted),
      .err_retire     (err_retire)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Launch-level model: how many TIDs went out, whether issuing has stopped, credits held.
   bit m_active, m_stop, m_done_now, m_aborted, m_err;
   int m_issued, m_last, m_inflight;

   int       ret_mode;   // 0 manual, 1 retire two cycles after issue, 2 random
   int       p_ready;    // <0 manual, else percent chance of ready
   bit       rand_abort;
   bit [1:0] pipe;

   function automatic bit exp_tv();
      return m_active && !m_stop && (m_inflight < int'(MAXI));
   endfunction

   function automatic int exp_tid();
      return (m_issued < m_last) ? m_issued : m_last;
   endfunction

   task automatic model_reset();
      m_active = 0; m_stop = 0; m_done_now = 0; m_aborted = 0; m_err = 0;
      m_issued = 0; m_last = 0; m_inflight = 0; pipe = '0;
   endtask

   task automatic model_edge();
      bit hs, ret_ok, uf;
      int nin;
      hs     = exp_tv() && tid_ready;
      ret_ok = retire_valid && (m_inflight > 0);
      uf     = retire_valid && (m_inflight == 0);
      nin    = m_inflight + int'(hs) - int'(ret_ok);
      if (m_done_now) begin
         m_done_now = 0;
         m_err      = m_err | uf;
      end else if (!m_active) begin
         if (launch_valid) begin
            m_active  = 1;
            m_issued  = 0;
            m_stop    = 0;
            m_aborted = 0;
            m_err     = uf;
            m_last    = (int'(launch_max_tid) > int'(TOTAL) - 1) ? int'(TOTAL) - 1 : int'(launch_max_tid);
         end else begin
            m_err = m_err | uf;
         end
      end else begin
         m_err = m_err | uf;
         if (!m_stop) begin
            if (hs) begin
               m_issued++;
               if (m_issued > m_last) m_stop = 1;
            end
            if (abort) begin
               m_stop    = 1;
               m_aborted = 1;
            end
         end else if (nin == 0) begin
            m_active   = 0;
            m_done_now = 1;
         end
      end
      m_inflight = nin;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".tid_valid"},    32'(tid_valid),    32'(exp_tv()));
      chk({tag, ".tid"},          32'(tid),          32'(exp_tid()));
      chk({tag, ".inflight"},     32'(inflight),     32'(m_inflight));
      chk({tag, ".busy"},         32'(busy),         32'(m_active || m_done_now));
      chk({tag, ".launch_ready"}, 32'(launch_ready), 32'(!(m_active || m_done_now)));
      chk({tag, ".done"},         32'(done),         32'(m_done_now));
      chk({tag, ".aborted"},      32'(aborted),      32'(m_aborted));
      chk({tag, ".err_retire"},   32'(err_retire),   32'(m_err));
   endtask

   // Called at a negedge: settle inputs, advance model, clock, then check.
   task automatic tick(input string tag);
      bit hs;
      if (ret_mode == 1) retire_valid = pipe[1];
      else if (ret_mode == 2) retire_valid = ($urandom_range(0, 99) < 40);
      if (p_ready >= 0) tid_ready = ($urandom_range(0, 99) < p_ready);
      if (rand_abort) abort = ($urandom_range(0, 99) < 3);
      hs = exp_tv() && tid_ready;
      model_edge();
      @(posedge clk);
      pipe = {pipe[0], hs};
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic launch(input int lmt, input string tag);
      if (m_done_now) tick({tag, ".idle"});
      launch_valid   = 1'b1;
      launch_max_tid = TIDW'(lmt);
      tick({tag, ".accept"});
      launch_valid   = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k = 0;
      while (!m_done_now && k < budget) begin
         tick(tag);
         k++;
      end
      chk({tag, ".done_seen"}, 32'(done), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      rst_n = 1'b0; launch_valid = 1'b0; launch_max_tid = '0; abort = 1'b0;
      tid_ready = 1'b0; retire_valid = 1'b0;
      ret_mode = 0; p_ready = -1; rand_abort = 0;
      model_reset();
      @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      tick("post_reset");

      // Basic: four TIDs back to back, each retired two cycles later.
      tid_ready = 1'b1; ret_mode = 1;
      launch(3, "basic");
      chk("basic.first_tid", 32'(tid), 32'd0);
      chk("basic.first_valid", 32'(tid_valid), 32'd1);
      wait_done(20, "basic");
      chk("basic.aborted", 32'(aborted), 32'd0);

      // Credit stall with no retires, then a single retire frees one slot.
      ret_mode = 0; retire_valid = 1'b0;
      launch(9, "stall");
      repeat (6) tick("stall");
      chk("stall.inflight", 32'(inflight), 32'd4);
      chk("stall.valid_low", 32'(tid_valid), 32'd0);
      retire_valid = 1'b1;
      tick("stall.retire");
      retire_valid = 1'b0;
      chk("stall.reissue_valid", 32'(tid_valid), 32'd1);
      chk("stall.reissue_tid", 32'(tid), 32'd4);
      tick("stall.issue4");
      ret_mode = 2;
      wait_done(300, "stall");

      // Backpressure: tid held stable while ready is low.
      ret_mode = 1; tid_ready = 1'b1;
      launch(5, "bp");
      tick("bp.first");
      tid_ready = 1'b0;
      repeat (5) begin
         tick("bp.hold");
         chk("bp.tid_stable", 32'(tid), 32'd1);
         chk("bp.valid_high", 32'(tid_valid), 32'd1);
      end
      tid_ready = 1'b1;
      wait_done(30, "bp");

      // Abort coinciding with the tid 2 handshake.
      ret_mode = 0; retire_valid = 1'b0;
      launch(9, "abort");
      tick("abort.t0");
      tick("abort.t1");
      chk("abort.at_tid2", 32'(tid), 32'd2);
      abort = 1'b1;
      tick("abort.edge");
      abort = 1'b0;
      chk("abort.inflight", 32'(inflight), 32'd3);
      retire_valid = 1'b1;
      wait_done(5, "abort");
      retire_valid = 1'b0;
      chk("abort.flag", 32'(aborted), 32'd1);
      tick("abort.idle");

      // Single-TID launch and clamped oversize launch.
      ret_mode = 1;
      launch(0, "max0");
      wait_done(10, "max0");
      launch(600, "clamp");
      wait_done(700, "clamp");
      chk("clamp.last_tid", 32'(tid), 32'd511);

      // Issue and retire on the same edge at inflight == MAX-1.
      ret_mode = 0; retire_valid = 1'b0;
      launch(9, "simul");
      repeat (3) tick("simul.fill");
      chk("simul.pre_inflight", 32'(inflight), 32'd3);
      retire_valid = 1'b1;
      tick("simul.both");
      retire_valid = 1'b0;
      chk("simul.inflight", 32'(inflight), 32'd3);
      chk("simul.valid", 32'(tid_valid), 32'd1);
      ret_mode = 2;
      wait_done(300, "simul");

      // Spurious retire while idle.
      ret_mode = 0;
      tick("err.idle");
      retire_valid = 1'b1;
      tick("err.retire");
      retire_valid = 1'b0;
      chk("err.flag", 32'(err_retire), 32'd1);
      chk("err.inflight", 32'(inflight), 32'd0);

      // Randomized launches with random ready, retire and abort.
      ret_mode = 2; p_ready = 70; rand_abort = 1;
      for (int i = 0; i < 8; i++) begin
         launch(($urandom_range(0, 9) == 0) ? 600 : int'($urandom_range(0, 20)), "rand");
         wait_done(3000, "rand");
      end
      rand_abort = 0; abort = 1'b0; p_ready = -1;

      // Reset in the middle of issuing.
      ret_mode = 0; retire_valid = 1'b0; tid_ready = 1'b1;
      launch(9, "rst_mid");
      tick("rst_mid.t0");
      tick("rst_mid.t1");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid.async");
      chk("rst_mid.busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick("rst_mid.after");
      chk("rst_mid.no_done", 32'(done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tid_launch_controller.md
Name: tid_launch_controller

Overview:
Sequences one CGRA kernel launch: accepts a launch command carrying the last thread ID, and issues TIDs 0..max_tid to the CGRA fabric over a valid/ready handshake. It limits in-flight threads with a credit counter fed by thread-retire pulses, and signals completion once every issued thread has retired. Sits between the core's launch/CSR logic and the CGRA thread-injection port, replacing free-running TID generation with flow-controlled, completion-tracked issue.

Parameters:
TOTAL_TID, 512, maximum threads per launch; TID width TIDW = $clog2(TOTAL_TID+1)
MAX_INFLIGHT, 16, maximum issued-but-not-retired threads (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
launch_valid  input  1  launch command valid
launch_ready  output  1  controller can accept a launch
launch_max_tid  input  TIDW  last TID of launch (inclusive)
abort  input  1  stop issuing; drain and finish
tid_valid  output  1  TID offered to fabric
tid_ready  input  1  fabric accepts TID
tid  output  TIDW  TID being offered
retire_valid  input  1  one thread retired this cycle
inflight  output  $clog2(MAX_INFLIGHT+1)  current in-flight count
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
aborted  output  1  last launch ended via abort; valid with done, held until next launch accept
err_retire  output  1  sticky: retire seen with inflight==0; cleared on launch accept

Behaviour:
- Reset (async, rst_n low): state IDLE, next_tid=0, max_tid_q=0, inflight=0, done=0, aborted=0, err_retire=0. Outputs: tid_valid=0, tid=0, launch_ready=1, busy=0. Reset mid-launch discards all state; no done is produced.
- All outputs are functions of registers only; no input-to-output combinational path.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: launch_ready=1. On launch_valid: max_tid_q = min(launch_max_tid, TOTAL_TID-1), next_tid=0, clear aborted and err_retire, go to ISSUE. tid_valid rises in the next cycle.
- ISSUE: tid=next_tid; tid_valid = (inflight < MAX_INFLIGHT).
  - Handshake when tid_valid && tid_ready: inflight+1.
  - If next_tid==max_tid_q, go to DRAIN; else next_tid+1.
  - tid_valid, once high, stays high with tid stable until the handshake, except on abort.
- abort in ISSUE: go to DRAIN next cycle and set aborted. A handshake in the same cycle still counts and is issued. abort in other states is ignored.
- DRAIN: tid_valid=0. When inflight==0 at the clock edge (including reaching 0 that cycle), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in ISSUE/DRAIN/DONE.
- inflight update per edge: +1 on handshake, -1 on retire, unchanged when both occur.
  - A retire with inflight==0 is ignored and sets err_retire, in any state.
  - inflight never exceeds MAX_INFLIGHT and never wraps.
- Retire at the same edge that inflight would hit MAX_INFLIGHT: the net update applies, so tid_valid stays high.
- max_tid 0 is legal: exactly one TID (0) is issued.
- No retire timeout; DRAIN waits indefinitely.

Optional Feature:
TID_LAUNCH_PERF_EN: when defined, adds output ports issue_stall_cycles (32 bits) and launch_cycles (32 bits).
- issue_stall_cycles counts ISSUE cycles where tid_valid=0 (credit stall) or tid_ready=0.
- launch_cycles counts cycles from launch accept through DONE.
- Both counters clear on launch accept, saturate at all-ones, and hold after DONE.
When the macro is undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Package tid_launch_pkg: state enum type (IDLE/ISSUE/DRAIN/DONE), function tid_width(total) returning $clog2(total+1).
- One natural sub-module, credit_counter: up/down counter with limit, full flag and underflow flag, parameterized by MAX.

Test Plan:
- Basic: launch max_tid=3, tid_ready=1, each TID retired 2 cycles after issue -> tids 0,1,2,3 on consecutive cycles starting cycle after accept; done single pulse after last retire; aborted=0.
- Credit stall: MAX_INFLIGHT=4, max_tid=9, no retires -> 4 TIDs issued, tid_valid=0 with inflight=4; one retire -> tid 4 issued next cycle.
- Backpressure: tid_ready low 5 cycles while tid_valid=1 -> tid held at same value and valid stays high; issues on ready.
- Abort: abort at cycle tid=2 handshaking -> tids 0..2 issued only; done after 3 retires with aborted=1.
- Boundaries: max_tid=0 -> one TID; launch_max_tid=600 with TOTAL_TID=512 -> last tid=511; simultaneous issue+retire at inflight=MAX-1 leaves inflight unchanged.
- Errors/reset: retire in IDLE -> err_retire=1, inflight stays 0; rst_n low mid-ISSUE -> all outputs at reset values, no done pulse.
